// File: rtl/pulse_train_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_train_gen_if
// Brief    : Control/status bundle between a pulse-train generator and its user.
// Revision : 1.0 - initial release
// ============================================================================
interface pulse_train_gen_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] pulse_cnt;
  logic             sig_out;
  logic             busy;
  logic             done;
  logic             rise_strb;
  logic             fall_strb;

  // Controller side: issues commands, observes the waveform.
  modport master (
    output start, abort, high_len, low_len, pulse_cnt,
    input  sig_out, busy, done, rise_strb, fall_strb
  );

  // Generator side.
  modport slave (
    input  start, abort, high_len, low_len, pulse_cnt,
    output sig_out, busy, done, rise_strb, fall_strb
  );
endinterface
`default_nettype wire

// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module   : pulse_train_gen
// Brief    : Programmable pulse-train generator with aligned rise/fall strobes.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_train_gen #(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  pulse_train_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_zero = '0;
  localparam logic [CNT_W-1:0] c_one  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_phase_cnt;
  logic [CNT_W-1:0] w_phase_nxt;
  logic [CNT_W-1:0] r_pulses_left;
  logic [CNT_W-1:0] w_pulses_nxt;
  logic [CNT_W-1:0] r_high_m1;
  logic [CNT_W-1:0] w_high_m1_nxt;
  logic [CNT_W-1:0] r_low_m1;
  logic [CNT_W-1:0] w_low_m1_nxt;
  logic             r_sig;
  logic             w_sig_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_rise;
  logic             r_fall;
  logic             w_start_ok;
  logic [CNT_W-1:0] w_high_len_m1;
  logic [CNT_W-1:0] w_low_len_m1;

  // Phase counters hold "cycles remaining minus one", so a zero length maps
  // to a single cycle and the full-scale length never needs an extra bit.
  assign w_high_len_m1 = (bus.high_len == c_zero) ? c_zero : bus.high_len - c_one;
  assign w_low_len_m1  = (bus.low_len  == c_zero) ? c_zero : bus.low_len  - c_one;
  assign w_start_ok    = bus.start && !bus.abort && (bus.pulse_cnt != c_zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_phase_cnt   <= c_zero;
      r_pulses_left <= c_zero;
      r_high_m1     <= c_zero;
      r_low_m1      <= c_zero;
      r_sig         <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_rise        <= 1'b0;
      r_fall        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase_cnt   <= w_phase_nxt;
      r_pulses_left <= w_pulses_nxt;
      r_high_m1     <= w_high_m1_nxt;
      r_low_m1      <= w_low_m1_nxt;
      r_sig         <= w_sig_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_rise        <= w_sig_nxt & ~r_sig;
      r_fall        <= ~w_sig_nxt & r_sig;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase_cnt;
    w_pulses_nxt  = r_pulses_left;
    w_high_m1_nxt = r_high_m1;
    w_low_m1_nxt  = r_low_m1;
    w_sig_nxt     = r_sig;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_sig_nxt  = 1'b0;
        w_busy_nxt = 1'b0;
        if (w_start_ok) begin
          w_state_nxt   = S_HIGH;
          w_high_m1_nxt = w_high_len_m1;
          w_low_m1_nxt  = w_low_len_m1;
          w_pulses_nxt  = bus.pulse_cnt;
          w_phase_nxt   = w_high_len_m1;
          w_sig_nxt     = 1'b1;
          w_busy_nxt    = 1'b1;
        end
      end

      S_HIGH: begin
        if (bus.abort) begin
          w_state_nxt  = S_IDLE;
          w_phase_nxt  = c_zero;
          w_pulses_nxt = c_zero;
          w_sig_nxt    = 1'b0;
          w_busy_nxt   = 1'b0;
        end else if (r_phase_cnt == c_zero) begin
          if (r_pulses_left > c_one) begin
            w_state_nxt  = S_LOW;
            w_pulses_nxt = r_pulses_left - c_one;
            w_phase_nxt  = r_low_m1;
            w_sig_nxt    = 1'b0;
          end else begin
            // Last pulse ends straight into IDLE; no trailing low phase.
            w_state_nxt  = S_IDLE;
            w_pulses_nxt = c_zero;
            w_sig_nxt    = 1'b0;
            w_busy_nxt   = 1'b0;
            w_done_nxt   = 1'b1;
          end
        end else begin
          w_phase_nxt = r_phase_cnt - c_one;
        end
      end

      S_LOW: begin
        if (bus.abort) begin
          w_state_nxt  = S_IDLE;
          w_phase_nxt  = c_zero;
          w_pulses_nxt = c_zero;
          w_sig_nxt    = 1'b0;
          w_busy_nxt   = 1'b0;
        end else if (r_phase_cnt == c_zero) begin
          w_state_nxt = S_HIGH;
          w_phase_nxt = r_high_m1;
          w_sig_nxt   = 1'b1;
        end else begin
          w_phase_nxt = r_phase_cnt - c_one;
        end
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_phase_nxt  = c_zero;
        w_pulses_nxt = c_zero;
        w_sig_nxt    = 1'b0;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  assign bus.sig_out   = r_sig;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.rise_strb = r_rise;
  assign bus.fall_strb = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_train_gen
// Brief    : Self-checking bench for pulse_train_gen against a train-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_train_gen;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   cyc;

  pulse_train_gen_if #(.CNT_W(8)) bus ();

  pulse_train_gen #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a train is a list of cycles, index k from 0; the signal is
  // high when k mod (H+L) < H, and the train lasts N*H + (N-1)*L cycles.
  bit m_active;
  int m_k, m_total, m_h, m_l;
  bit m_sig, m_busy, m_done, m_rise, m_fall;

  task automatic model_reset();
    m_active = 0; m_k = 0; m_total = 0; m_h = 1; m_l = 1;
    m_sig = 0; m_busy = 0; m_done = 0; m_rise = 0; m_fall = 0;
  endtask

  function automatic logic [4:0] dut_outs();
    return {bus.sig_out, bus.busy, bus.done, bus.rise_strb, bus.fall_strb};
  endfunction

  function automatic logic [4:0] model_outs();
    return {m_sig, m_busy, m_done, m_rise, m_fall};
  endfunction

  task automatic tick();
    bit nsig, ndone;
    int n;
    @(posedge clk);
    nsig = 0;
    ndone = 0;
    if (m_active) begin
      if (bus.abort) begin
        m_active = 0;
      end else begin
        m_k++;
        if (m_k == m_total) begin
          m_active = 0;
          ndone = 1;
        end else begin
          nsig = ((m_k % (m_h + m_l)) < m_h);
        end
      end
    end else if (bus.start && !bus.abort && bus.pulse_cnt != 0) begin
      m_h = (bus.high_len == 0) ? 1 : int'(bus.high_len);
      m_l = (bus.low_len == 0) ? 1 : int'(bus.low_len);
      n = int'(bus.pulse_cnt);
      m_total = n * m_h + (n - 1) * m_l;
      m_k = 0;
      m_active = 1;
      nsig = 1;
    end
    m_rise = nsig & ~m_sig;
    m_fall = ~nsig & m_sig;
    m_sig  = nsig;
    m_done = ndone;
    m_busy = m_active;
    #1;
    cyc++;
  endtask

  task automatic set_params(input int h, input int l, input int n);
    bus.high_len  = 8'(h);
    bus.low_len   = 8'(l);
    bus.pulse_cnt = 8'(n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vectors++;
    if (dut_outs() !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_async outs=%b expected=%b", dut_outs(), 5'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (dut_outs() !== model_outs()) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d outs=%b expected=%b", i, dut_outs(), model_outs());
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] sig_tbl;
    sig_tbl = 8'b11000110;
    set_params(2, 3, 2);
    bus.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      bus.start = 1'b0;
      vectors++;
      if (dut_outs() !== model_outs()) begin
        miscompares++;
        $display("FAIL basic cyc=%0d outs=%b expected=%b", c, dut_outs(), model_outs());
      end
      if (c <= 8) begin
        vectors++;
        if (bus.sig_out !== sig_tbl[8-c]) begin
          miscompares++;
          $display("FAIL basic_table cyc=%0d sig_out=%b expected=%b", c, bus.sig_out, sig_tbl[8-c]);
        end
      end
    end
  endtask

  task automatic test_zero_fields();
    set_params(0, 0, 3);
    bus.start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      bus.start = 1'b0;
      vectors++;
      if (dut_outs() !== model_outs()) begin
        miscompares++;
        $display("FAIL zero_len cyc=%0d outs=%b expected=%b", c, dut_outs(), model_outs());
      end
    end
    set_params(2, 3, 0);
    bus.start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.start = 1'b0;
      vectors++;
      if (dut_outs() !== 5'b0) begin
        miscompares++;
        $display("FAIL zero_count cyc=%0d outs=%b expected=%b", c, dut_outs(), 5'b0);
      end
    end
  endtask

  task automatic test_abort();
    set_params(2, 3, 2);
    bus.start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      bus.start = 1'b0;
      bus.abort = (c == 1);
      vectors++;
      if (dut_outs() !== model_outs()) begin
        miscompares++;
        $display("FAIL abort_high cyc=%0d outs=%b expected=%b", c, dut_outs(), model_outs());
      end
    end
    bus.abort = 1'b0;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      vectors++;
      if (dut_outs() !== 5'b0) begin
        miscompares++;
        $display("FAIL abort_with_start cyc=%0d outs=%b expected=%b", c, dut_outs(), 5'b0);
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [7:0] sig_tbl;
    sig_tbl = 8'b11000110;
    set_params(2, 3, 2);
    bus.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      bus.start = (c == 2);
      if (c == 2) bus.high_len = 8'd7;
      vectors++;
      if (dut_outs() !== model_outs()) begin
        miscompares++;
        $display("FAIL ignored_start cyc=%0d outs=%b expected=%b", c, dut_outs(), model_outs());
      end
      if (c <= 8) begin
        vectors++;
        if (bus.sig_out !== sig_tbl[8-c]) begin
          miscompares++;
          $display("FAIL ignored_table cyc=%0d sig_out=%b expected=%b", c, bus.sig_out, sig_tbl[8-c]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_params(2, 3, 2);
    bus.start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.start = 1'b0;
    end
    #4;
    rst = 1'b1;
    #1;
    vectors++;
    if (dut_outs() !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_mid outs=%b expected=%b", dut_outs(), 5'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tick();
    set_params(2, 3, 2);
    bus.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      bus.start = 1'b0;
      vectors++;
      if (dut_outs() !== model_outs()) begin
        miscompares++;
        $display("FAIL reset_restart cyc=%0d outs=%b expected=%b", c, dut_outs(), model_outs());
      end
    end
  endtask

  task automatic test_back_to_back();
    int fall_at, rise_at;
    fall_at = -1;
    rise_at = -1;
    set_params(2, 3, 2);
    bus.start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      bus.start = 1'b0;
      vectors++;
      if (dut_outs() !== model_outs()) begin
        miscompares++;
        $display("FAIL back_to_back cyc=%0d outs=%b expected=%b", c, dut_outs(), model_outs());
      end
      if (c == 8) bus.start = 1'b1;
      if (bus.done === 1'b1 && fall_at < 0) fall_at = c;
      if (fall_at >= 0 && c > fall_at && bus.rise_strb === 1'b1 && rise_at < 0) rise_at = c;
    end
    vectors++;
    if (fall_at != 8 || rise_at != 9) begin
      miscompares++;
      $display("FAIL back_to_back_gap done_at=%0d next_rise_at=%0d expected 8 and 9", fall_at, rise_at);
    end
  endtask

  task automatic test_width_limit();
    int highs;
    highs = 0;
    set_params(255, 4, 1);
    bus.start = 1'b1;
    for (int c = 1; c <= 260; c++) begin
      tick();
      bus.start = 1'b0;
      if (bus.sig_out === 1'b1) highs++;
      vectors++;
      if (dut_outs() !== model_outs()) begin
        miscompares++;
        $display("FAIL width_limit cyc=%0d outs=%b expected=%b", c, dut_outs(), model_outs());
      end
    end
    vectors++;
    if (highs != 255) begin
      miscompares++;
      $display("FAIL width_limit_count high_cycles=%0d expected=255", highs);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.start     = ($urandom_range(0, 5) == 0);
      bus.abort     = ($urandom_range(0, 30) == 0);
      bus.high_len  = 8'($urandom_range(0, 4));
      bus.low_len   = 8'($urandom_range(0, 4));
      bus.pulse_cnt = 8'($urandom_range(0, 3));
      tick();
      vectors++;
      if (dut_outs() !== model_outs()) begin
        miscompares++;
        $display("FAIL random cyc=%0d outs=%b expected=%b", c, dut_outs(), model_outs());
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_params(0, 0, 0);
    model_reset();
    #1;
    test_reset();
    test_basic();
    idle(3);
    test_zero_fields();
    idle(3);
    test_abort();
    idle(3);
    test_ignored_start();
    idle(3);
    test_reset_mid();
    idle(3);
    test_back_to_back();
    idle(3);
    test_width_limit();
    idle(3);
    test_random();
    idle(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
